// File: rtl/streaming_maximum_search_if.sv
// ============================================================================
// Module      : streaming_maximum_search_if
// Description : Sample-in / result-out handshake bundle for the serial max search.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface streaming_maximum_search_if #(
    parameter int WIDTH = 8,
    parameter int IDX_W = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_bits;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_max;
    logic [IDX_W-1:0] out_index;
    logic [IDX_W-1:0] count;

    // Producer/consumer side of the block.
    modport master (
        output in_valid, in_bits, flush, out_ready,
        input  in_ready, out_valid, out_max, out_index, count
    );

    // The search block itself.
    modport slave (
        input  in_valid, in_bits, flush, out_ready,
        output in_ready, out_valid, out_max, out_index, count
    );
endinterface

`default_nettype wire

// File: rtl/streaming_maximum_search.sv
// ============================================================================
// Module      : streaming_maximum_search
// Description : Serial running-maximum search over COUNT-sample frames.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module streaming_maximum_search #(
    parameter int WIDTH = 8,
    parameter int COUNT = 10,
    parameter int IDX_W = 4
) (
    input  wire logic                        clock,
    input  wire logic                        reset,
    streaming_maximum_search_if.slave        io
);
    localparam logic [0:0]       ACCUM = 1'b0;
    localparam logic [0:0]       DONE  = 1'b1;
    localparam logic [IDX_W-1:0] LAST  = IDX_W'(COUNT - 1);

    logic [0:0]       state;
    logic [IDX_W-1:0] count;
    logic [WIDTH-1:0] max_val;
    logic [IDX_W-1:0] max_idx;
    logic             accept;

    // Handshake flags decode straight from state so reset reaches them without a clock.
    assign io.in_ready  = (state == ACCUM);
    assign io.out_valid = (state == DONE);
    assign io.out_max   = max_val;
    assign io.out_index = max_idx;
    assign io.count     = count;

    assign accept = io.in_valid && (state == ACCUM) && !io.flush;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state   <= ACCUM;
            count   <= '0;
            max_val <= '0;
            max_idx <= '0;
        end else begin
            case (state)
                ACCUM: begin
                    if (io.flush) begin
                        count <= '0;
                    end else if (accept) begin
                        // First sample seeds the frame; later ones replace only when strictly larger.
                        if (count == '0) begin
                            max_val <= io.in_bits;
                            max_idx <= '0;
                        end else if (io.in_bits > max_val) begin
                            max_val <= io.in_bits;
                            max_idx <= count;
                        end
                        if (count == LAST) begin
                            state <= DONE;
                            count <= '0;
                        end else begin
                            count <= count + 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (io.flush || io.out_ready) begin
                        state <= ACCUM;
                    end
                end
                default: begin
                    state <= ACCUM;
                    count <= '0;
                end
            endcase
        end
    end
endmodule

`default_nettype wire

// File: tb/tb_streaming_maximum_search.sv
// ============================================================================
// Module      : tb_streaming_maximum_search
// Description : Directed self-checking bench for streaming_maximum_search.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_streaming_maximum_search;
    logic clock;
    logic reset;
    int   total;
    int   bad;
    int   consumed;
    int   snap;
    logic [7:0] frame [10];

    streaming_maximum_search_if #(.WIDTH(8), .IDX_W(4)) io ();

    streaming_maximum_search #(.WIDTH(8), .COUNT(10), .IDX_W(4)) dut (
        .clock (clock),
        .reset (reset),
        .io    (io.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Results actually taken by the consumer (a flush in the same cycle drops it).
    always @(posedge clock)
        if (io.out_valid && io.out_ready && !io.flush) consumed <= consumed + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic push(input logic [7:0] b);
        io.in_valid = 1'b1;
        io.in_bits  = b;
        tick();
        io.in_valid = 1'b0;
        io.in_bits  = 8'hAA;
    endtask

    task automatic run_frame(input int max_gap);
        for (int i = 0; i < 10; i++) begin
            repeat ($urandom_range(max_gap, 0)) tick();
            push(frame[i]);
        end
    endtask

    initial begin
        total = 0; bad = 0; consumed = 0;
        reset = 1'b0;
        io.in_valid = 1'b0; io.in_bits = '0; io.flush = 1'b0; io.out_ready = 1'b0;
        #2;
        check("rst_in_ready",  32'(io.in_ready),  1);
        check("rst_out_valid", 32'(io.out_valid), 0);
        check("rst_count",     32'(io.count),     0);
        check("rst_max",       32'(io.out_max),   0);
        check("rst_index",     32'(io.out_index), 0);
        @(negedge clock); @(negedge clock);
        reset = 1'b1;
        tick();

        // Frame 1: tie on 9 keeps earliest index; result visible one cycle after 10th accept.
        io.out_ready = 1'b1;
        frame = '{8'd3, 8'd7, 8'd1, 8'd9, 8'd2, 8'd9, 8'd0, 8'd5, 8'd8, 8'd4};
        for (int i = 0; i < 9; i++) push(frame[i]);
        check("f1_valid_early", 32'(io.out_valid), 0);
        check("f1_count9",      32'(io.count),     9);
        push(frame[9]);
        check("f1_valid",   32'(io.out_valid), 1);
        check("f1_in_rdy",  32'(io.in_ready),  0);
        check("f1_max",     32'(io.out_max),   9);
        check("f1_index",   32'(io.out_index), 3);
        check("f1_count0",  32'(io.count),     0);
        tick();
        check("f1_consumed", 32'(io.out_valid), 0);
        check("f1_rdy_back", 32'(io.in_ready),  1);

        // Frame 2 and 3: the new frame must not inherit the old maximum.
        frame = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        run_frame(0);
        check("f2_max",   32'(io.out_max),   255);
        check("f2_index", 32'(io.out_index), 0);
        tick();
        frame = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd1};
        run_frame(0);
        check("f3_max",   32'(io.out_max),   1);
        check("f3_index", 32'(io.out_index), 9);
        tick();

        // Frame 4: valid gaps, then consumer stalls 20 cycles while samples keep arriving.
        io.out_ready = 1'b0;
        frame = '{8'd10, 8'd9, 8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
        run_frame(2);
        snap = consumed;
        io.in_valid = 1'b1; io.in_bits = 8'd99;
        for (int i = 0; i < 20; i++) begin
            check("f4_in_rdy", 32'(io.in_ready),  0);
            check("f4_valid",  32'(io.out_valid), 1);
            check("f4_max",    32'(io.out_max),   10);
            check("f4_index",  32'(io.out_index), 0);
            tick();
        end
        io.in_valid = 1'b0;
        io.out_ready = 1'b1;
        repeat (3) tick();
        check("f4_one_result", 32'(consumed - snap), 1);
        check("f4_rdy_back",   32'(io.in_ready),     1);

        // Flush after 4 samples (flush beats a coincident sample), then a clean frame.
        push(8'd200); push(8'd1); push(8'd2); push(8'd3);
        check("fl_count4", 32'(io.count), 4);
        io.flush = 1'b1; io.in_valid = 1'b1; io.in_bits = 8'd250;
        tick();
        io.flush = 1'b0; io.in_valid = 1'b0;
        check("fl_count0", 32'(io.count), 0);
        frame = '{8'd5, 8'd6, 8'd7, 8'd8, 8'd9, 8'd10, 8'd11, 8'd12, 8'd13, 8'd14};
        run_frame(0);
        check("fl_max",   32'(io.out_max),   14);
        check("fl_index", 32'(io.out_index), 9);
        tick();

        // Asynchronous reset mid-frame, observed before the next clock edge.
        for (int i = 0; i < 6; i++) push(8'(50 + 10 * i));
        check("ar_count6", 32'(io.count), 6);
        #2 reset = 1'b0;
        #1;
        check("ar_valid",  32'(io.out_valid), 0);
        check("ar_in_rdy", 32'(io.in_ready),  1);
        check("ar_count",  32'(io.count),     0);
        #3 reset = 1'b1;
        tick();
        frame = '{8'd4, 8'd4, 8'd20, 8'd3, 8'd20, 8'd19, 8'd0, 8'd1, 8'd2, 8'd7};
        run_frame(1);
        check("ar_max",   32'(io.out_max),   20);
        check("ar_index", 32'(io.out_index), 2);
        tick();

        // Flush in DONE together with out_ready: result dropped, back to ACCUM.
        io.out_ready = 1'b0;
        frame = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9, 8'd0};
        run_frame(0);
        check("fd_valid", 32'(io.out_valid), 1);
        check("fd_max",   32'(io.out_max),   9);
        check("fd_index", 32'(io.out_index), 8);
        snap = consumed;
        io.flush = 1'b1; io.out_ready = 1'b1;
        tick();
        io.flush = 1'b0; io.out_ready = 1'b0;
        check("fd_valid_off", 32'(io.out_valid),   0);
        check("fd_in_rdy",    32'(io.in_ready),    1);
        check("fd_no_result", 32'(consumed - snap), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

`default_nettype wire
